mux2_1_rr_merge: RTL and testbench

//  Upstream select/flow-control stage for the 2:1 mux datapath: merges two valid/ready

---
 rtl/mux2_1_rr_merge_pkg.sv | 17 +
 rtl/mux2_1_rr_merge_if.sv | 34 +++
 rtl/mux2_1.sv | 18 +
 rtl/mux2_1_rr_merge_rr_arb2.sv | 25 ++
 rtl/mux2_1_rr_merge.sv | 86 ++++++++
 tb/tb_mux2_1_rr_merge.sv | 198 +++++++++++++++++++
 6 files changed

// File: rtl/mux2_1_rr_merge_pkg.sv
// ----------------------------------------------------------------------------
// mux2_1_rr_merge_pkg
// Shared definitions for the 2:1 round-robin merge stage:
//   CH0 / CH1          channel index constants (also the mux select values)
//   state_t            output register state (ST_EMPTY / ST_FULL)
// ----------------------------------------------------------------------------
package mux2_1_rr_merge_pkg;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/mux2_1_rr_merge_if.sv
// ----------------------------------------------------------------------------
// mux2_1_rr_merge_if
// Bundles the two input valid/ready streams and the merged output stream.
//   in0_valid/in0_data/in0_ready   channel 0 stream
//   in1_valid/in1_data/in1_ready   channel 1 stream
//   out_valid/out_data/out_src/out_ready   merged output stream
// Modports:
//   slave  - the merge stage (consumes inputs, produces output)
//   master - the environment (produces inputs, consumes output)
// ----------------------------------------------------------------------------
interface mux2_1_rr_merge_if #(
    parameter int WIDTH = 8
);
    logic             in0_valid;
    logic [WIDTH-1:0] in0_data;
    logic             in0_ready;
    logic             in1_valid;
    logic [WIDTH-1:0] in1_data;
    logic             in1_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_src;
    logic             out_ready;

    modport slave (
        input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
        output in0_ready, in1_ready, out_valid, out_data, out_src
    );

    modport master (
        output in0_valid, in0_data, in1_valid, in1_data, out_ready,
        input  in0_ready, in1_ready, out_valid, out_data, out_src
    );
endinterface

// File: rtl/mux2_1.sv
// ----------------------------------------------------------------------------
// mux2_1
// Plain 2:1 multiplexer, WIDTH bits wide.
//   i_i0  selected when i_s = 0
//   i_i1  selected when i_s = 1
//   i_s   select
//   o_y   selected value
// ----------------------------------------------------------------------------
module mux2_1 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_i0,
    input  logic [WIDTH-1:0] i_i1,
    input  logic             i_s,
    output logic [WIDTH-1:0] o_y
);
    assign o_y = i_s ? i_i1 : i_i0;
endmodule

// File: rtl/mux2_1_rr_merge_rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Combinational two-requester round-robin arbiter.
//   i_req[1:0]  request per channel
//   i_last      channel granted most recently (the other wins a tie)
//   i_en        arbitration enabled (no grant when low)
//   o_gnt[1:0]  one-hot grant, all zero when nothing is granted
//   o_gnt_idx   index of the granted channel (CH0 when nothing is granted)
// ----------------------------------------------------------------------------
module rr_arb2
    import mux2_1_rr_merge_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    input  logic       i_en,
    output logic [1:0] o_gnt,
    output logic       o_gnt_idx
);
    always_comb begin
        // A lone requester always wins; on a tie the channel not served last wins.
        o_gnt[0]  = i_en & i_req[0] & (~i_req[1] | i_last);
        o_gnt[1]  = i_en & i_req[1] & (~i_req[0] | ~i_last);
        o_gnt_idx = o_gnt[1] ? CH1 : CH0;
    end
endmodule

// File: rtl/mux2_1_rr_merge.sv
// ----------------------------------------------------------------------------
// mux2_1_rr_merge
// Merges two valid/ready streams into one registered output stream using
// round-robin arbitration. The granted index drives the 2:1 data mux select
// and is reported on out_src with each beat. A single output register is
// reloaded in the same cycle it drains, so throughput is one beat per cycle.
// Ports:
//   clk    clock, all state on posedge
//   rst_n  synchronous reset, active-low
//   bus    mux2_1_rr_merge_if.slave (both input streams + output stream)
// ----------------------------------------------------------------------------
module mux2_1_rr_merge
    import mux2_1_rr_merge_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mux2_1_rr_merge_if.slave       bus
);
    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_data;
    logic             r_src;
    logic             r_last;

    logic             w_load;
    logic             w_en;
    logic [1:0]       w_gnt;
    logic             w_gnt_idx;
    logic             w_xfer;
    logic [WIDTH-1:0] w_sel_data;

    // The register can take a new beat when it is empty or being drained now.
    // Reset blocks acceptance so nothing is handshaken into a register being cleared.
    assign w_load = (r_state == ST_EMPTY) | bus.out_ready;
    assign w_en   = w_load & rst_n;

    // Readies deliberately ignore their own channel's valid.
    assign bus.in0_ready = w_en & (~bus.in1_valid | r_last);
    assign bus.in1_ready = w_en & (~bus.in0_valid | ~r_last);

    rr_arb2 u_arb (
        .i_req     ({bus.in1_valid, bus.in0_valid}),
        .i_last    (r_last),
        .i_en      (w_en),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx)
    );

    assign w_xfer = |w_gnt;

    mux2_1 #(.WIDTH(WIDTH)) u_mux (
        .i_i0 (bus.in0_data),
        .i_i1 (bus.in1_data),
        .i_s  (w_gnt_idx),
        .o_y  (w_sel_data)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (w_load) begin
            w_state_nxt = w_xfer ? ST_FULL : ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_data  <= '0;
            r_src   <= CH0;
            r_last  <= CH1;
        end else begin
            r_state <= w_state_nxt;
            if (w_xfer) begin
                r_data <= w_sel_data;
                r_src  <= w_gnt_idx;
                r_last <= w_gnt_idx;
            end
        end
    end

    assign bus.out_valid = (r_state == ST_FULL);
    assign bus.out_data  = r_data;
    assign bus.out_src   = r_src;
endmodule

// File: tb/tb_mux2_1_rr_merge.sv
module tb_mux2_1_rr_merge;
    logic clk = 1'b0;
    logic rst_n;
    int   vec = 0;
    int   err = 0;

    always #5 clk = ~clk;

    mux2_1_rr_merge_if #(.WIDTH(8)) ifc ();

    mux2_1_rr_merge #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: what the output register must hold, and whose turn it is.
    bit       m_valid = 0;
    bit [7:0] m_data  = 0;
    bit       m_src   = 0;
    bit       m_last  = 1;
    bit [7:0] q0[$];
    bit [7:0] q1[$];

    // Inputs change at posedge+2, so at negedge they are exactly what the next edge sees.
    always @(negedge clk) begin
        bit e0, e1, load, g_any, g;
        bit [7:0] pd;
        load = !m_valid || ifc.out_ready;
        e0 = 0; e1 = 0;
        if (rst_n && load) begin
            // A channel may take a beat unless the other is waiting and it is the other's turn.
            e0 = !ifc.in1_valid || (m_last == 1'b1);
            e1 = !ifc.in0_valid || (m_last == 1'b0);
        end
        chk("in0_ready", ifc.in0_ready, e0);
        chk("in1_ready", ifc.in1_ready, e1);
        chk("out_valid", ifc.out_valid, m_valid);
        if (m_valid) begin
            chk("out_data", ifc.out_data, m_data);
            chk("out_src", ifc.out_src, m_src);
        end
        // Scoreboard: each beat delivered downstream is the oldest accepted from its source.
        if (rst_n && ifc.out_valid === 1'b1 && ifc.out_ready) begin
            if (ifc.out_src === 1'b0 && q0.size() > 0) begin
                pd = q0.pop_front();
                chk("sb_src0", ifc.out_data, pd);
            end else if (ifc.out_src === 1'b1 && q1.size() > 0) begin
                pd = q1.pop_front();
                chk("sb_src1", ifc.out_data, pd);
            end else begin
                chk("sb_unexpected_beat", 1, 0);
            end
        end
        // Advance the model to the state after the coming edge.
        if (!rst_n) begin
            m_valid = 0; m_data = 0; m_src = 0; m_last = 1;
            q0.delete(); q1.delete();
        end else if (load) begin
            g_any = ifc.in0_valid || ifc.in1_valid;
            if (ifc.in0_valid && ifc.in1_valid) g = !m_last;
            else g = ifc.in1_valid;
            m_valid = g_any;
            if (g_any) begin
                m_data = g ? ifc.in1_data : ifc.in0_data;
                m_src  = g;
                m_last = g;
                if (g) q1.push_back(m_data);
                else   q0.push_back(m_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit v0, input bit [7:0] d0, input bit v1, input bit [7:0] d1, input bit ordy);
        ifc.in0_valid = v0; ifc.in0_data = d0;
        ifc.in1_valid = v1; ifc.in1_data = d1;
        ifc.out_ready = ordy;
    endtask

    task automatic chk_out(input string nm, input bit v, input bit [7:0] d, input bit s);
        chk({nm, "_valid"}, ifc.out_valid, v);
        if (v) begin
            chk({nm, "_data"}, ifc.out_data, d);
            chk({nm, "_src"}, ifc.out_src, s);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [7:0] exp_d[4];
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h11; exp_d[3] = 8'h22;

        // Reset with random inputs
        rst_n = 0;
        drive($urandom_range(0, 1), 8'($urandom), $urandom_range(0, 1), 8'($urandom), $urandom_range(0, 1));
        tick();
        tick();
        chk("rst_out_valid", ifc.out_valid, 0);
        chk("rst_out_data", ifc.out_data, 8'h00);
        chk("rst_out_src", ifc.out_src, 0);
        chk("rst_in0_ready", ifc.in0_ready, 0);
        chk("rst_in1_ready", ifc.in1_ready, 0);

        // Single source
        rst_n = 1;
        drive(1, 8'hA5, 0, 8'h00, 1);
        #1 chk("single_in0_ready", ifc.in0_ready, 1);
        tick();
        chk_out("single", 1, 8'hA5, 0);

        // Drain: one cycle high, then empty with readies up
        drive(0, 8'h00, 0, 8'h00, 1);
        tick();
        chk("drain_out_valid", ifc.out_valid, 0);
        chk("drain_in0_ready", ifc.in0_ready, 1);
        chk("drain_in1_ready", ifc.in1_ready, 1);
        tick();
        chk("drain_out_valid2", ifc.out_valid, 0);

        // Re-centre the pointer, then tie round-robin
        rst_n = 0;
        tick();
        rst_n = 1;
        drive(1, 8'h11, 1, 8'h22, 1);
        #1 chk("tie_in0_ready", ifc.in0_ready, 1);
        chk("tie_in1_ready", ifc.in1_ready, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out($sformatf("tie%0d", i), 1, exp_d[i], 1'(i % 2));
        end

        // Backpressure: fill with 11, stall 3 cycles
        tick();
        chk_out("bp_fill", 1, 8'h11, 0);
        ifc.out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_in0_ready", ifc.in0_ready, 0);
            chk("bp_in1_ready", ifc.in1_ready, 0);
            tick();
            chk_out("bp_hold", 1, 8'h11, 0);
        end
        ifc.out_ready = 1;
        tick();
        chk_out("bp_rel0", 1, 8'h22, 1);
        tick();
        chk_out("bp_rel1", 1, 8'h11, 0);

        // Reset mid-stall
        drive(1, 8'h5A, 0, 8'h00, 1);
        tick();
        chk_out("ms_fill", 1, 8'h5A, 0);
        drive(0, 8'h00, 0, 8'h00, 0);
        tick();
        chk_out("ms_stall", 1, 8'h5A, 0);
        rst_n = 0;
        #1 chk("ms_rst_in0_ready", ifc.in0_ready, 0);
        tick();
        chk("ms_out_valid", ifc.out_valid, 0);
        chk("ms_out_data", ifc.out_data, 8'h00);
        rst_n = 1;
        drive(1, 8'h11, 1, 8'h22, 1);
        tick();
        chk_out("ms_tie", 1, 8'h11, 0);

        // Mixed traffic checked by the model and scoreboard
        for (int i = 0; i < 300; i++) begin
            rst_n = ($urandom_range(0, 60) != 0);
            drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0, 8'($urandom),
                  $urandom_range(0, 2) != 0);
            tick();
        end
        rst_n = 1;
        drive(0, 8'h00, 0, 8'h00, 1);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
